sr_pipe_fde: RTL and testbench
==============================

SR_PIPE_FDE -- requirements
Module: sr_pipe_fde

Interface
REQ-001 SHALL have no parameters; all widths fixed (XLEN 32, register index 5).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 freeze  in  1  stall request from hazard/branch control.
REQ-005 pc_i  in  32  fetch address chosen by external PC logic.
REQ-006 imAddr_o  out  32  instruction memory address, combinationally equal to pc_i.
REQ-007 imData_i  in  32  instruction word at imAddr_o (combinational memory).
REQ-008 pcPlus4_f_o  out  32  IF/ID register pc+4, for sequential next-PC.
REQ-009 rs1_o, rs2_o  out  5 each  source indices of the IF/ID instruction (instr[19:15], instr[24:20]), for register-file read.
REQ-010 branch_d_o  out  1  ID/EX branch flag, for branch control.
REQ-011 srcA_i, srcB_i  in  32 each  forwarded operand values for the ID/EX instruction.
REQ-012 EX/WB outputs: wdSrc_o, regWrite_o, branch_o, condZero_o, aluZero_o (1 each); aluResult_o, immU_o, pcBranch_o, pcPlus4_o (32 each); rd_o (5).

Function
REQ-013 Three register stages, posedge clk: IF/ID (instr, pc, pc+4), ID/EX (decoded controls, rd, immI, immU, pcBranch, pc+4), EX/WB (all outputs of REQ-012).
REQ-014 Latency: word on imData_i at edge n reaches IF/ID at n, ID/EX at n+1, EX/WB at n+2.
REQ-015 Decode: OP 0110011 -> ADD (f3 000,f7 0000000), SUB (000,0100000), OR (110), SRL (101,0000000), SLTU (011); regWrite=1, aluSrc=0.
REQ-016 Decode: OP-IMM 0010011 f3 000 -> ADDI, aluControl ADD, aluSrc=1, regWrite=1.
REQ-017 Decode: LUI 0110111 -> regWrite=1, wdSrc=1; BRANCH 1100011 f3 000 -> BEQ (branch=1, condZero=1, SUB), f3 001 -> BNE (branch=1, condZero=0, SUB).
REQ-018 Any other encoding (including 0x00000000) SHALL decode as NOP: regWrite, branch, wdSrc, condZero, aluSrc all 0, aluControl ADD.
REQ-019 aluControl codes: ADD 000, OR 001, SRL 010, SLTU 011, SUB 100; unused codes yield result 0.
REQ-020 immI = sign-extended instr[31:20]; immU = {instr[31:12],12'h000}; immB = sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],0}; pcBranch = pc + immB, mod 2^32.
REQ-021 Execute: operand B = aluSrc ? immI : srcB_i; ADD/SUB wrap mod 2^32; SRL shifts by B[4:0] logically; SLTU unsigned compare -> 1 or 0.
REQ-022 aluZero_o = (aluResult == 0); all other ID/EX fields pass unchanged into EX/WB.
REQ-023 rd_o = instr[11:7] for every instruction, including NOPs and branches.
REQ-024 freeze=1 at an edge: IF/ID holds its value; ID/EX loads a NOP (REQ-018 controls, other fields don't-care-but-deterministic 0); EX/WB advances normally.
REQ-025 freeze=0 at the edge following a freeze: the held IF/ID instruction advances into ID/EX normally.

Reset
REQ-026 rst=1 at an edge clears every stage register to 0 (instr=0 i.e. NOP, all controls 0, all data 0); rst dominates freeze.
REQ-027 After reset, pcPlus4_f_o=0, regWrite_o=0, branch_o=0 until real instructions propagate.

Verification
REQ-028 Reset then ADDI x1,x0,5 (0x00500093) with srcA_i=0 -> two edges later regWrite_o=1, rd_o=1, aluResult_o=5, aluZero_o=0.
REQ-029 LUI x2,0x12345 -> EX/WB wdSrc_o=1, immU_o=0x12345000, regWrite_o=1, rd_o=2.
REQ-030 SUB with srcA_i=srcB_i=7 -> aluResult_o=0, aluZero_o=1; SLTU srcA=1, srcB=0xFFFFFFFF -> aluResult_o=1; SRL 0x80000000 by 31 -> 1.
REQ-031 BEQ offset -8 at pc_i=0x20 -> branch_d_o=1 one edge after fetch; EX/WB branch_o=1, condZero_o=1, pcBranch_o=0x18, pcPlus4_o=0x24.
REQ-032 freeze held 2 edges with ADD in IF/ID -> two NOP bubbles (regWrite_o=0) exit EX/WB, then the ADD emerges once, unduplicated.
REQ-033 rst asserted mid-stream with valid instructions in all stages -> next edge all outputs 0, regWrite_o=0.

Source files
------------

// File: rtl/sr_pipe_fde.sv
// sr_pipe_fde: fetch / decode / execute front end of a small RV32 core.
// An instruction word read combinationally from instruction memory is
// captured in IF/ID, decoded into ID/EX, and executed into EX/WB.
//
// Ports
//   clk, rst        clock; synchronous active-high reset that clears all stages
//   freeze          stall: hold IF/ID, inject a NOP bubble into ID/EX
//   pc_i            fetch address from the external PC logic
//   imAddr_o        instruction memory address (equal to pc_i)
//   imData_i        instruction word at imAddr_o
//   pcPlus4_f_o     IF/ID pc+4 for sequential next-PC
//   rs1_o, rs2_o    IF/ID source register indices for the register file
//   branch_d_o      ID/EX branch flag for branch control
//   srcA_i, srcB_i  forwarded operands for the ID/EX instruction
//   wdSrc_o .. rd_o EX/WB results and controls
module sr_pipe_fde (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [31:0] pc_i,
    output logic [31:0] imAddr_o,
    input  logic [31:0] imData_i,
    output logic [31:0] pcPlus4_f_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        branch_d_o,
    input  logic [31:0] srcA_i,
    input  logic [31:0] srcB_i,
    output logic        wdSrc_o,
    output logic        regWrite_o,
    output logic        branch_o,
    output logic        condZero_o,
    output logic        aluZero_o,
    output logic [31:0] aluResult_o,
    output logic [31:0] immU_o,
    output logic [31:0] pcBranch_o,
    output logic [31:0] pcPlus4_o,
    output logic [4:0]  rd_o
);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SRL  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    function automatic logic [31:0] alu_op(input logic [2:0]  ctrl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (ctrl)
            ALU_ADD:  alu_op = a + b;
            ALU_OR:   alu_op = a | b;
            ALU_SRL:  alu_op = a >> b[4:0];
            ALU_SLTU: alu_op = {31'd0, (a < b)};
            ALU_SUB:  alu_op = a - b;
            default:  alu_op = 32'd0;
        endcase
    endfunction

    // ---------------- IF -> IF/ID ----------------
    logic [31:0] instr_p0;
    logic [31:0] pc_p0;
    logic [31:0] pc_plus4_p0;

    assign imAddr_o = pc_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p0    <= 32'd0;
            pc_p0       <= 32'd0;
            pc_plus4_p0 <= 32'd0;
        end else if (!freeze) begin
            instr_p0    <= imData_i;
            pc_p0       <= pc_i;
            pc_plus4_p0 <= pc_i + 32'd4;
        end
    end

    assign pcPlus4_f_o = pc_plus4_p0;
    assign rs1_o       = instr_p0[19:15];
    assign rs2_o       = instr_p0[24:20];

    // ---------------- ID -> ID/EX ----------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_p0[6:0];
    assign funct3 = instr_p0[14:12];
    assign funct7 = instr_p0[31:25];

    logic       dec_reg_write, dec_branch, dec_wd_src, dec_cond_zero, dec_alu_src;
    logic [2:0] dec_alu_ctrl;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_branch    = 1'b0;
        dec_wd_src    = 1'b0;
        dec_cond_zero = 1'b0;
        dec_alu_src   = 1'b0;
        dec_alu_ctrl  = ALU_ADD;
        case (opcode)
            OP_REG: begin
                dec_reg_write = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_alu_ctrl = ALU_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_alu_ctrl = ALU_SUB;
                else if (funct3 == 3'b110)                         dec_alu_ctrl = ALU_OR;
                else if (funct3 == 3'b101 && funct7 == 7'b0000000) dec_alu_ctrl = ALU_SRL;
                else if (funct3 == 3'b011)                         dec_alu_ctrl = ALU_SLTU;
                else                                               dec_reg_write = 1'b0;
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_reg_write = 1'b1;
                    dec_alu_src   = 1'b1;
                end
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_wd_src    = 1'b1;
            end
            OP_BR: begin
                // BEQ takes the branch on a zero difference, BNE on non-zero.
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec_branch    = 1'b1;
                    dec_cond_zero = (funct3 == 3'b000);
                    dec_alu_ctrl  = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_b;
    logic        [31:0] imm_u;
    assign imm_i = {{20{instr_p0[31]}}, instr_p0[31:20]};
    assign imm_b = {{19{instr_p0[31]}}, instr_p0[31], instr_p0[7], instr_p0[30:25],
                    instr_p0[11:8], 1'b0};
    assign imm_u = {instr_p0[31:12], 12'h000};

    logic        reg_write_p1, branch_p1, wd_src_p1, cond_zero_p1, alu_src_p1;
    logic [2:0]  alu_ctrl_p1;
    logic [4:0]  rd_p1;
    logic [31:0] imm_i_p1, imm_u_p1, pc_branch_p1, pc_plus4_p1;

    // A freeze injects an all-zero bubble, which decodes to the NOP controls.
    always_ff @(posedge clk) begin
        if (rst || freeze) begin
            reg_write_p1 <= 1'b0;
            branch_p1    <= 1'b0;
            wd_src_p1    <= 1'b0;
            cond_zero_p1 <= 1'b0;
            alu_src_p1   <= 1'b0;
            alu_ctrl_p1  <= ALU_ADD;
            rd_p1        <= 5'd0;
            imm_i_p1     <= 32'd0;
            imm_u_p1     <= 32'd0;
            pc_branch_p1 <= 32'd0;
            pc_plus4_p1  <= 32'd0;
        end else begin
            reg_write_p1 <= dec_reg_write;
            branch_p1    <= dec_branch;
            wd_src_p1    <= dec_wd_src;
            cond_zero_p1 <= dec_cond_zero;
            alu_src_p1   <= dec_alu_src;
            alu_ctrl_p1  <= dec_alu_ctrl;
            rd_p1        <= instr_p0[11:7];
            imm_i_p1     <= imm_i;
            imm_u_p1     <= imm_u;
            pc_branch_p1 <= pc_p0 + $unsigned(imm_b);
            pc_plus4_p1  <= pc_plus4_p0;
        end
    end

    assign branch_d_o = branch_p1;

    // ---------------- EX -> EX/WB ----------------
    logic [31:0] opnd_b;
    logic [31:0] alu_res;
    assign opnd_b  = alu_src_p1 ? imm_i_p1 : srcB_i;
    assign alu_res = alu_op(alu_ctrl_p1, srcA_i, opnd_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdSrc_o     <= 1'b0;
            regWrite_o  <= 1'b0;
            branch_o    <= 1'b0;
            condZero_o  <= 1'b0;
            aluZero_o   <= 1'b0;
            aluResult_o <= 32'd0;
            immU_o      <= 32'd0;
            pcBranch_o  <= 32'd0;
            pcPlus4_o   <= 32'd0;
            rd_o        <= 5'd0;
        end else begin
            wdSrc_o     <= wd_src_p1;
            regWrite_o  <= reg_write_p1;
            branch_o    <= branch_p1;
            condZero_o  <= cond_zero_p1;
            aluZero_o   <= (alu_res == 32'd0);
            aluResult_o <= alu_res;
            immU_o      <= imm_u_p1;
            pcBranch_o  <= pc_branch_p1;
            pcPlus4_o   <= pc_plus4_p1;
            rd_o        <= rd_p1;
        end
    end

endmodule

// File: tb/tb_sr_pipe_fde.sv
module tb_sr_pipe_fde;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic [31:0] pc_i, imAddr_o, imData_i, pcPlus4_f_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        branch_d_o;
    logic [31:0] srcA_i, srcB_i;
    logic        wdSrc_o, regWrite_o, branch_o, condZero_o, aluZero_o;
    logic [31:0] aluResult_o, immU_o, pcBranch_o, pcPlus4_o;

    sr_pipe_fde dut (
        .clk(clk), .rst(rst), .freeze(freeze), .pc_i(pc_i), .imAddr_o(imAddr_o),
        .imData_i(imData_i), .pcPlus4_f_o(pcPlus4_f_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .branch_d_o(branch_d_o), .srcA_i(srcA_i), .srcB_i(srcB_i),
        .wdSrc_o(wdSrc_o), .regWrite_o(regWrite_o), .branch_o(branch_o),
        .condZero_o(condZero_o), .aluZero_o(aluZero_o), .aluResult_o(aluResult_o),
        .immU_o(immU_o), .pcBranch_o(pcBranch_o), .pcPlus4_o(pcPlus4_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr, pc, a, b;
        logic [4:0]  rs1, rs2;
        logic        br_d, rw, wd, br, cz, zero;
        logic [31:0] alu;
        logic        chk_alu;
        logic [4:0]  rd;
        logic [31:0] immu, pcb;
        logic        chk_pcb;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl[12];

    initial begin
        //          name    instr         pc     a             b             rs1 rs2 bd rw wd br cz z  alu           ca rd  immu          pcb    cp pc4
        tbl[0]  = '{"addi", 32'h00500093, 32'h00, 32'h0,        32'h1234,     0,  5,  0, 1, 0, 0, 0, 0, 32'h5,        1, 1,  32'h00500000, 32'h800, 1, 32'h04};
        tbl[1]  = '{"lui",  32'h12345137, 32'h04, 32'h0,        32'h0,        8,  3,  0, 1, 1, 0, 0, 0, 32'h0,        0, 2,  32'h12345000, 32'h126, 1, 32'h08};
        tbl[2]  = '{"sub",  32'h402081B3, 32'h08, 32'h7,        32'h7,        1,  2,  0, 1, 0, 0, 0, 1, 32'h0,        1, 3,  32'h40208000, 32'h0,   0, 32'h0C};
        tbl[3]  = '{"sltu", 32'h0020B233, 32'h0C, 32'h1,        32'hFFFFFFFF, 1,  2,  0, 1, 0, 0, 0, 0, 32'h1,        1, 4,  32'h0020B000, 32'h0,   0, 32'h10};
        tbl[4]  = '{"srl",  32'h0020D2B3, 32'h10, 32'h80000000, 32'd31,       1,  2,  0, 1, 0, 0, 0, 0, 32'h1,        1, 5,  32'h0020D000, 32'h0,   0, 32'h14};
        tbl[5]  = '{"or",   32'h0020E333, 32'h14, 32'hF0F00000, 32'h0000F0F0, 1,  2,  0, 1, 0, 0, 0, 0, 32'hF0F0F0F0, 1, 6,  32'h0020E000, 32'h0,   0, 32'h18};
        tbl[6]  = '{"addw", 32'h002083B3, 32'h18, 32'hFFFFFFFF, 32'h1,        1,  2,  0, 1, 0, 0, 0, 1, 32'h0,        1, 7,  32'h00208000, 32'h0,   0, 32'h1C};
        tbl[7]  = '{"beq",  32'hFE208CE3, 32'h20, 32'h5,        32'h5,        1,  2,  1, 0, 0, 1, 1, 1, 32'h0,        1, 25, 32'hFE208000, 32'h18,  1, 32'h24};
        tbl[8]  = '{"bne",  32'h00209863, 32'h40, 32'h3,        32'h5,        1,  2,  1, 0, 0, 1, 0, 0, 32'hFFFFFFFE, 1, 16, 32'h00209000, 32'h50,  1, 32'h44};
        tbl[9]  = '{"zero", 32'h00000000, 32'h60, 32'h2,        32'h3,        0,  0,  0, 0, 0, 0, 0, 0, 32'h5,        1, 0,  32'h00000000, 32'h60,  1, 32'h64};
        tbl[10] = '{"mul",  32'h022083B3, 32'h64, 32'd10,       32'd20,       1,  2,  0, 0, 0, 0, 0, 0, 32'd30,       1, 7,  32'h02208000, 32'h0,   0, 32'h68};
        tbl[11] = '{"addin",32'hFFF08413, 32'h68, 32'h0,        32'h5,        1,  31, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 8,  32'hFFF08000, 32'h0,   0, 32'h6C};

        rst = 1'b1; freeze = 1'b0; pc_i = 32'h0; imData_i = 32'h0; srcA_i = 32'h0; srcB_i = 32'h0;
        @(negedge clk);
        cyc();
        cyc();
        check("rst_pcplus4_f", pcPlus4_f_o, 32'h0);
        check("rst_regwrite", {31'd0, regWrite_o}, 32'h0);
        check("rst_branch", {31'd0, branch_o}, 32'h0);
        check("rst_branch_d", {31'd0, branch_d_o}, 32'h0);
        check("rst_alu", aluResult_o, 32'h0);
        check("rst_rd", {27'd0, rd_o}, 32'h0);
        rst = 1'b0;
        pc_i = 32'h12345678;
        #1 check("imaddr", imAddr_o, 32'h12345678);

        // Each vector travels alone: fetch, decode, execute, then compare.
        for (int i = 0; i < 12; i++) begin
            imData_i = tbl[i].instr; pc_i = tbl[i].pc;
            cyc();
            imData_i = 32'h0; pc_i = 32'h0;
            srcA_i = tbl[i].a; srcB_i = tbl[i].b;
            check({tbl[i].name, "_pcplus4_f"}, pcPlus4_f_o, tbl[i].pc4);
            check({tbl[i].name, "_rs1"}, {27'd0, rs1_o}, {27'd0, tbl[i].rs1});
            check({tbl[i].name, "_rs2"}, {27'd0, rs2_o}, {27'd0, tbl[i].rs2});
            cyc();
            check({tbl[i].name, "_branch_d"}, {31'd0, branch_d_o}, {31'd0, tbl[i].br_d});
            cyc();
            check({tbl[i].name, "_regwrite"}, {31'd0, regWrite_o}, {31'd0, tbl[i].rw});
            check({tbl[i].name, "_wdsrc"}, {31'd0, wdSrc_o}, {31'd0, tbl[i].wd});
            check({tbl[i].name, "_branch"}, {31'd0, branch_o}, {31'd0, tbl[i].br});
            check({tbl[i].name, "_condzero"}, {31'd0, condZero_o}, {31'd0, tbl[i].cz});
            check({tbl[i].name, "_rd"}, {27'd0, rd_o}, {27'd0, tbl[i].rd});
            check({tbl[i].name, "_immu"}, immU_o, tbl[i].immu);
            check({tbl[i].name, "_pcplus4"}, pcPlus4_o, tbl[i].pc4);
            if (tbl[i].chk_alu) begin
                check({tbl[i].name, "_alu"}, aluResult_o, tbl[i].alu);
                check({tbl[i].name, "_aluzero"}, {31'd0, aluZero_o}, {31'd0, tbl[i].zero});
            end
            if (tbl[i].chk_pcb)
                check({tbl[i].name, "_pcbranch"}, pcBranch_o, tbl[i].pcb);
        end

        // Freeze for two edges with ADD x7,x1,x2 held in IF/ID.
        imData_i = 32'h0; srcA_i = 32'h0; srcB_i = 32'h0;
        cyc(); cyc(); cyc();
        imData_i = 32'h002083B3; pc_i = 32'h100;
        cyc();
        imData_i = 32'h0; pc_i = 32'h200; freeze = 1'b1;
        cyc();
        check("frz1_regwrite", {31'd0, regWrite_o}, 32'h0);
        cyc();
        check("frz2_bubble1", {31'd0, regWrite_o}, 32'h0);
        check("frz2_hold_pcplus4_f", pcPlus4_f_o, 32'h104);
        check("frz2_hold_rs2", {27'd0, rs2_o}, 32'd2);
        freeze = 1'b0; srcA_i = 32'd2; srcB_i = 32'd3;
        cyc();
        check("frz3_bubble2", {31'd0, regWrite_o}, 32'h0);
        check("frz3_branch_d", {31'd0, branch_d_o}, 32'h0);
        cyc();
        check("frz4_add_regwrite", {31'd0, regWrite_o}, 32'h1);
        check("frz4_add_alu", aluResult_o, 32'd5);
        check("frz4_add_rd", {27'd0, rd_o}, 32'd7);
        check("frz4_add_pcplus4", pcPlus4_o, 32'h104);
        cyc();
        check("frz5_no_dup", {31'd0, regWrite_o}, 32'h0);

        // Reset in the middle of a full pipeline, with freeze also high.
        srcA_i = 32'h1; srcB_i = 32'h0;
        imData_i = 32'h00500093; pc_i = 32'h30; cyc();
        imData_i = 32'h12345137; pc_i = 32'h34; cyc();
        imData_i = 32'h002083B3; pc_i = 32'h38; cyc();
        check("pre_rst_regwrite", {31'd0, regWrite_o}, 32'h1);
        check("pre_rst_alu", aluResult_o, 32'h6);
        rst = 1'b1; freeze = 1'b1; imData_i = 32'hFE208CE3; pc_i = 32'h3C;
        cyc();
        check("mid_rst_regwrite", {31'd0, regWrite_o}, 32'h0);
        check("mid_rst_wdsrc", {31'd0, wdSrc_o}, 32'h0);
        check("mid_rst_rd", {27'd0, rd_o}, 32'h0);
        check("mid_rst_alu", aluResult_o, 32'h0);
        check("mid_rst_immu", immU_o, 32'h0);
        check("mid_rst_pcbranch", pcBranch_o, 32'h0);
        check("mid_rst_pcplus4", pcPlus4_o, 32'h0);
        check("mid_rst_pcplus4_f", pcPlus4_f_o, 32'h0);
        check("mid_rst_rs1", {27'd0, rs1_o}, 32'h0);
        check("mid_rst_branch_d", {31'd0, branch_d_o}, 32'h0);
        rst = 1'b0; freeze = 1'b0; imData_i = 32'h0;
        cyc();
        check("post_rst_regwrite", {31'd0, regWrite_o}, 32'h0);
        check("post_rst_branch", {31'd0, branch_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
